// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes and FSM states.
package alu_mc_pkg;

  // 4-bit op field; the original 3-bit codes keep their values with a 0 MSB.
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the controller and the multi-cycle ALU.
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// the requester holds op/data1/data2 and in_valid until then. A response
// transfers on a rising edge where out_valid && out_ready; the ALU holds all
// result fields stable while out_valid is high and out_ready is low.
interface alu_mc_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             ovf;
  logic             div0;

  modport master (
    output in_valid, op, data1, data2, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, ovf, div0
  );

  modport slave (
    input  in_valid, op, data1, data2, out_ready,
    output in_ready, out_valid, result, result_hi, zero, ovf, div0
  );
endinterface

// File: rtl/alu_mc_iter.sv
// Shared iterative datapath for unsigned multiply (shift-add) and unsigned
// divide (restoring). The {hi, lo} pair is the accumulator for both; the
// *_next outputs expose the value one step ahead so the caller can capture
// the final step directly into its output registers.
module alu_mc_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] operand;
  logic             div_mode;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;

  // One iteration step: MULU adds the multiplicand when lo[0] is set then
  // shifts right; DIVU shifts left and subtracts the divisor if it fits.
  // The partial remainder needs WIDTH+1 bits before the trial subtract.
  always_comb begin
    hi_next = hi;
    lo_next = lo;
    sum     = '0;
    rem     = '0;
    diff    = '0;
    if (div_mode) begin
      rem  = {hi, lo[WIDTH-1]};
      diff = rem[WIDTH-1:0] - operand;
      if (rem >= {1'b0, operand}) begin
        hi_next = diff;
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = rem[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

  // Accumulator and latched operand: load starts a new operation, step advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      operand  <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      hi       <= '0;
      lo       <= a;
      operand  <= b;
      div_mode <= is_div;
    end else if (step) begin
      hi <= hi_next;
      lo <= lo_next;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith/shift ops complete in
// one cycle; MULU and DIVU iterate WIDTH cycles in alu_mc_iter.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus,
  output state_t   state
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] diff_ab;

  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_ovf;
  logic             sc_div0;

  logic             accept;
  logic             start_iter;
  logic [WIDTH-1:0] it_hi_next;
  logic [WIDTH-1:0] it_lo_next;

  logic [CW-1:0]    count;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  logic             zero_q;
  logic             ovf_q;
  logic             div0_q;

  assign a       = bus.data1;
  assign b       = bus.data2;
  assign shamt   = b[SHW-1:0];
  assign sum_ab  = a + b;
  assign diff_ab = a - b;

  assign accept     = bus.in_valid && (state == S_IDLE);
  assign start_iter = (bus.op == OP_MULU) || ((bus.op == OP_DIVU) && (b != '0));

  // Single-cycle results; DIVU only reaches here with a zero divisor.
  always_comb begin
    sc_res  = '0;
    sc_hi   = '0;
    sc_ovf  = 1'b0;
    sc_div0 = 1'b0;
    case (bus.op)
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_NOR: sc_res = ~(a | b);
      OP_ADD: begin
        sc_res = sum_ab;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff_ab;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ab[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: sc_res = a << shamt;
      OP_SRL: sc_res = a >> shamt;
      OP_SRA: sc_res = $signed(a) >>> shamt;
      OP_DIVU: begin
        sc_res  = '1;
        sc_hi   = a;
        sc_div0 = 1'b1;
      end
      default: sc_res = '0;
    endcase
  end

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (accept && start_iter),
    .step    (state == S_BUSY),
    .is_div  (bus.op == OP_DIVU),
    .a       (a),
    .b       (b),
    .hi_next (it_hi_next),
    .lo_next (it_lo_next)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            if (start_iter) begin
              count <= CW'(WIDTH);
              state <= S_BUSY;
            end else begin
              result_q    <= sc_res;
              result_hi_q <= sc_hi;
              zero_q      <= (sc_res == '0);
              ovf_q       <= sc_ovf;
              div0_q      <= sc_div0;
              out_valid_q <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            result_q    <= it_lo_next;
            result_hi_q <= it_hi_next;
            zero_q      <= (it_lo_next == '0);
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.div0      = div0_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=32: directed cases, random ops with random
// consumer stalls, a stall with ignored requests, and a mid-multiply reset.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W  = 32;
  localparam int EW = 2 * W + 3;

  logic   clk;
  logic   reset;
  state_t state;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: {result_hi, result, zero, ovf, div0}
  function automatic logic [EW-1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W-1:0]   r;
    logic [W-1:0]   h;
    logic           v;
    logic           d;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    r = '0; h = '0; v = 1'b0; d = 1'b0; s = '0; p = '0;
    case (o)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: r = x ^ y;
      4'b0100: r = ~(x | y);
      4'b0010: begin s = {x[W-1], x} + {y[W-1], y}; r = s[W-1:0]; v = s[W] ^ s[W-1]; end
      4'b0110: begin s = {x[W-1], x} - {y[W-1], y}; r = s[W-1:0]; v = s[W] ^ s[W-1]; end
      4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: r = x << y[4:0];
      4'b1001: r = x >> y[4:0];
      4'b1010: r = $signed(x) >>> y[4:0];
      4'b1100: begin p = {32'd0, x} * {32'd0, y}; r = p[W-1:0]; h = p[2*W-1:W]; end
      4'b1101: begin
        if (y == '0) begin r = '1; h = x; d = 1'b1; end
        else begin r = x / y; h = x % y; end
      end
      default: r = '0;
    endcase
    return {h, r, (r == '0), v, d};
  endfunction

  function automatic logic [EW-1:0] observed();
    return {bus.result_hi, bus.result, bus.zero, bus.ovf, bus.div0};
  endfunction

  // Drive one request, check latency, pop/compare the scoreboard, optionally
  // stall the consumer, then complete the output handshake.
  // Latency is the number of rising edges after the accept edge before
  // out_valid is seen: single-cycle ops show it in the cycle right after accept.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int stall);
    int n;
    int exp_lat;
    logic busy_ok;
    logic hold_ok;
    logic [EW-1:0] e;
    logic [EW-1:0] held;
    exp_q.push_back(model(o, x, y));
    exp_lat = ((o == OP_MULU) || (o == OP_DIVU && y != '0)) ? W : 0;
    bus.op = o; bus.data1 = x; bus.data2 = y; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    tick();
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom_range(0, 15));
    bus.data1 = $urandom; bus.data2 = $urandom;
    n = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && n < 200) begin
      if (bus.in_ready) busy_ok = 1'b0;
      tick();
      n++;
    end
    check("latency", 128'(n), 128'(exp_lat));
    if (exp_lat != 0) check("busy_in_ready_low", 128'(busy_ok), 128'd1);
    check("out_valid", 128'(bus.out_valid), 128'd1);
    e = exp_q.pop_front();
    check("result", 128'(observed()), 128'(e));
    held = observed();
    hold_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = i[0];
      bus.op = OP_ADD; bus.data1 = $urandom; bus.data2 = $urandom;
      tick();
      if (observed() !== held || !bus.out_valid || bus.in_ready) hold_ok = 1'b0;
    end
    if (stall > 0) begin
      check("stall_hold", 128'(hold_ok), 128'd1);
      check("stall_state", 128'(state), 128'(S_DONE));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("valid_drop", 128'(bus.out_valid), 128'd0);
    check("ready_back", 128'(bus.in_ready), 128'd1);
  endtask

  // Abort an in-flight MULU with reset after 10 cycles; nothing may come out.
  task automatic abort_mulu();
    logic quiet;
    bus.op = OP_MULU; bus.data1 = 32'hFFFF_FFFF; bus.data2 = 32'h1234_5678;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    check("abort_busy", 128'(state), 128'(S_BUSY));
    reset = 1'b0;
    #1;
    check("abort_state", 128'(state), 128'(S_IDLE));
    check("abort_in_ready", 128'(bus.in_ready), 128'd1);
    check("abort_out_valid", 128'(bus.out_valid), 128'd0);
    check("abort_outputs", 128'(observed()), 128'd0);
    tick();
    reset = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      tick();
      if (bus.out_valid) quiet = 1'b0;
    end
    check("abort_no_result", 128'(quiet), 128'd1);
  endtask

  logic [3:0] op_tab[16];

  initial begin
    op_tab = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOR, OP_SUB, OP_SLT, OP_SLL,
               OP_SRL, OP_SRA, OP_MULU, OP_DIVU, OP_DIVU, 4'b0101, 4'b1011, 4'b1111};
    reset = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = OP_ADD; bus.data1 = 32'h7FFF_FFFF; bus.data2 = 32'h1;
    repeat (3) tick();
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_outputs", 128'(observed()), 128'd0);
    check("rst_state", 128'(state), 128'(S_IDLE));
    reset = 1'b1;

    // Directed cases
    run_op(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(OP_SUB,  32'd5,         32'd5,         0);
    run_op(OP_SUB,  32'h8000_0000, 32'h0000_0001, 0);
    run_op(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 0);
    run_op(OP_SRA,  32'h8000_0000, 32'h0000_0024, 0);
    run_op(OP_SRL,  32'h8000_0000, 32'h0000_0024, 0);
    run_op(OP_SLL,  32'h0000_0003, 32'hFFFF_FFE1, 0);
    run_op(OP_NOR,  32'h0F0F_0000, 32'h00F0_F0F0, 0);
    run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_DIVU, 32'd100,       32'd7,         5);
    run_op(OP_DIVU, 32'd9,         32'd0,         0);
    run_op(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    abort_mulu();

    // Random mix with random consumer stalls
    for (int k = 0; k < 40; k++) begin
      logic [3:0]   o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      o = op_tab[$urandom_range(0, 15)];
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : $urandom;
      if (o == OP_DIVU && $urandom_range(0, 2) == 0) y = '0;
      run_op(o, x, y, $urandom_range(0, 2));
    end

    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
